wb_unit: RTL and testbench
==========================

// Module: wb_unit
// PURPOSE
//   Write-back unit: the writer side of the register file that ID reads from.
//   Accepts one retiring instruction per handshake from EX/MEM.
//   For loads, issues a data-memory read, waits for the response, then aligns and extends
//   the byte/half/word. Writes the result to rd; writes to x0 are suppressed.
//   Sits between EX/MEM and the register file; the ID read ports see the data the cycle after rf_we.
// PARAMETERS
//   XLEN         32   datapath / address width
//   REG_ADDR_W   5    register index width (matches RS_WIDTH)
//   MEM_TIMEOUT  15   max LOAD_WAIT cycles without dmem_rvalid before error
// PORTS
//   clk            in   1           rising-edge clock
//   rst            in   1           asynchronous, active-low reset
//   req_valid      in   1           retire request valid
//   req_ready      out  1           unit can accept request (registered)
//   req_reg_write  in   1           instruction writes rd
//   req_is_load    in   1           instruction is a load
//   req_funct3     in   3           load type: 000 LB,001 LH,010 LW,100 LBU,101 LHU
//   req_rd         in   REG_ADDR_W  destination register
//   req_addr       in   XLEN        load effective address
//   req_alu_result in   XLEN        result for non-load instructions
//   dmem_rd_en     out  1           one-cycle read strobe
//   dmem_addr      out  XLEN        word-aligned read address {req_addr[XLEN-1:2],2'b00}
//   dmem_rvalid    in   1           read data valid
//   dmem_rdata     in   XLEN        read data word
//   rf_we          out  1           register-file write enable
//   rf_waddr       out  REG_ADDR_W  register-file write index
//   rf_wdata       out  XLEN        register-file write data
//   wb_done        out  1           one-cycle pulse: request retired (ok or error)
//   wb_err         out  1           one-cycle pulse with wb_done: misaligned/illegal/timeout
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; all outputs 0 incl. req_ready; timeout counter 0.
//   req_ready rises on the first clock edge after release.
// - Reset mid-load: abandons the request with no write. A late dmem_rvalid is ignored.
// - FSM states: IDLE, LOAD_REQ, LOAD_WAIT, WRITE, ERR.
//   req_ready=1 only in IDLE; handshake = req_valid & req_ready; all req_* captured then.
// - IDLE, non-load: go to WRITE with data = req_alu_result.
// - IDLE, load:
//   - funct3 in {011,110,111}, or LH/LHU with addr[0]=1, or LW with addr[1:0]!=0: go to ERR.
//   - otherwise: go to LOAD_REQ.
// - LOAD_REQ: dmem_rd_en=1 for exactly this cycle; dmem_addr held stable until leaving
//   LOAD_WAIT. Counter cleared. Go to LOAD_WAIT.
// - LOAD_WAIT: counter increments each cycle.
//   - dmem_rvalid=1: extract and extend data, go to WRITE. rvalid takes priority if it
//     arrives on the same cycle the counter reaches MEM_TIMEOUT.
//   - counter==MEM_TIMEOUT without rvalid: go to ERR.
//   - dmem_rvalid in any other state is ignored.
// - Extract on addr[1:0]:
//   - LB/LBU: byte addr[1:0], sign-/zero-extended.
//   - LH/LHU: half at addr[1], sign-/zero-extended.
//   - LW: full word.
// - WRITE (1 cycle):
//   - rf_we = reg_write & (rd!=0); rf_waddr=rd; rf_wdata=result; wb_done=1.
//   - Then go to IDLE.
//   - rf_waddr/rf_wdata are 0 whenever rf_we=0.
// - ERR (1 cycle): wb_done=1, wb_err=1, rf_we=0; go to IDLE.
// - Latency (accept at edge N):
//   - ALU write at N+1; ready again at N+2.
//   - Load: rd_en at N+1; rvalid earliest N+2; write one cycle after rvalid.
// STRUCTURE
// - Load funct3 encodings, state encoding and XLEN/RS_WIDTH macros live in riscv_def.v.
// - One sub-module: wb_load_align (combinational byte/half select plus extension).
//   It is shared with future MEM-stage work.
// TESTING
// 1. ALU: rd=5, result=0xDEADBEEF, reg_write=1.
//    -> rf_we=1 rf_waddr=5 rf_wdata=0xDEADBEEF one cycle after accept; wb_done pulse.
// 2. rd=0, result=0x1234.
//    -> rf_we stays 0; wb_done pulses; wb_err=0.
// 3. LB addr=0x103, rdata=0x80FF7F01 -> dmem_addr=0x100, rf_wdata=0xFFFFFF80.
//    LBU same -> 0x00000080.
//    LH addr=0x102 -> 0xFFFF80FF.
// 4. LW addr=0x102.
//    -> no dmem_rd_en; wb_done & wb_err pulse; rf_we=0.
//    funct3=011 -> same error response.
// 5. LW, rvalid withheld 15 cycles -> wb_err pulse, no write.
//    Repeat with rvalid exactly on cycle 15 -> normal write.
// 6. Reset asserted in LOAD_WAIT, then rvalid arrives after release.
//    -> outputs 0 immediately, no rf_we, req_ready=1 one edge after release.

Source files
------------

// File: rtl/wb_unit_pkg.sv
// ---------------------------------------------------------------------------
// wb_unit_pkg
//   Shared definitions for the write-back unit and its load aligner:
//   default widths, RISC-V load funct3 encodings, the write-back FSM state
//   type and a helper that classifies a load request as illegal/misaligned.
// ---------------------------------------------------------------------------
package wb_unit_pkg;

    localparam int XLEN_DEF        = 32;
    localparam int REG_ADDR_W_DEF  = 5;
    localparam int MEM_TIMEOUT_DEF = 15;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_REQ  = 3'd1,
        ST_LOAD_WAIT = 3'd2,
        ST_WRITE     = 3'd3,
        ST_ERR       = 3'd4
    } wb_state_e;

    // True when the load can never be serviced: unknown width encoding, a
    // halfword on an odd address, or a word that is not 4-byte aligned.
    function automatic logic load_is_bad(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = addr_lo[0];
            F3_LW:         bad = (addr_lo != 2'b00);
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// ---------------------------------------------------------------------------
// wb_load_align
//   Combinational load data aligner. Picks the byte or halfword addressed by
//   addr_lo out of a read word and sign- or zero-extends it; words pass
//   through unchanged. Kept as its own block so the MEM stage can reuse it.
//
//   funct3   in  3     load type (bit 2 set = unsigned)
//   addr_lo  in  2     low address bits of the load
//   rdata    in  XLEN  raw word returned by data memory
//   data     out XLEN  aligned, extended load result
// ---------------------------------------------------------------------------
module wb_load_align
    import wb_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        is_signed;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte  = byte_lane[addr_lo];
    // Halfword alignment is already guaranteed upstream, so only bit 1 matters.
    assign sel_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    assign is_signed = ~funct3[2];

    always_comb begin
        data = rdata;
        case (funct3[1:0])
            2'b00:   data = {{(XLEN-8){is_signed & sel_byte[7]}}, sel_byte};
            2'b01:   data = {{(XLEN-16){is_signed & sel_half[15]}}, sel_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// ---------------------------------------------------------------------------
// wb_unit
//   Write-back unit: writer side of the register file. Accepts one retiring
//   instruction per handshake. ALU results are written the cycle after
//   accept; loads issue a one-cycle data-memory read strobe, wait (bounded)
//   for the response, align/extend it and then write. Writes to x0 are
//   suppressed. Illegal/misaligned loads and memory timeouts retire with an
//   error pulse and no write.
//
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-low reset
//   req_valid      in   retire request valid
//   req_ready      out  unit can accept a request (registered)
//   req_reg_write  in   instruction writes rd
//   req_is_load    in   instruction is a load
//   req_funct3     in   load type
//   req_rd         in   destination register
//   req_addr       in   load effective address
//   req_alu_result in   result for non-load instructions
//   dmem_rd_en     out  one-cycle read strobe
//   dmem_addr      out  word-aligned read address (stable while loading)
//   dmem_rvalid    in   read data valid
//   dmem_rdata     in   read data word
//   rf_we          out  register-file write enable
//   rf_waddr       out  register-file write index (0 when rf_we=0)
//   rf_wdata       out  register-file write data  (0 when rf_we=0)
//   wb_done        out  one-cycle pulse: request retired
//   wb_err         out  one-cycle pulse with wb_done on error
// ---------------------------------------------------------------------------
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_reg_write,
    input  logic                  req_is_load,
    input  logic [2:0]            req_funct3,
    input  logic [REG_ADDR_W-1:0] req_rd,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [XLEN-1:0]       req_alu_result,
    output logic                  dmem_rd_en,
    output logic [XLEN-1:0]       dmem_addr,
    input  logic                  dmem_rvalid,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  wb_done,
    output logic                  wb_err
);

    localparam int              CNT_W       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    wb_state_e             state_reg, state_next;
    logic                  ready_reg;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [REG_ADDR_W-1:0] rd_reg;
    logic                  reg_write_reg;
    logic [2:0]            funct3_reg;
    logic [XLEN-1:0]       addr_reg;
    logic [XLEN-1:0]       result_reg;

    logic                  handshake;
    logic                  load_capture;
    logic                  write_en;
    logic [XLEN-1:0]       aligned_data;

    // ready_reg is only ever set when the FSM is headed for IDLE, so the
    // state check is belt-and-braces against a stray ready.
    assign handshake = req_valid & ready_reg & (state_reg == ST_IDLE);
    assign req_ready = ready_reg;
    assign write_en  = reg_write_reg & (rd_reg != '0);

    wb_load_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3  (funct3_reg),
        .addr_lo (addr_reg[1:0]),
        .rdata   (dmem_rdata),
        .data    (aligned_data)
    );

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            ready_reg     <= 1'b0;
            cnt_reg       <= '0;
            rd_reg        <= '0;
            reg_write_reg <= 1'b0;
            funct3_reg    <= 3'b000;
            addr_reg      <= '0;
            result_reg    <= '0;
        end else begin
            state_reg <= state_next;
            // Registered ready: low through reset, rises one edge after release.
            ready_reg <= (state_next == ST_IDLE);
            cnt_reg   <= cnt_next;
            if (handshake) begin
                rd_reg        <= req_rd;
                reg_write_reg <= req_reg_write;
                funct3_reg    <= req_funct3;
                addr_reg      <= req_addr;
                result_reg    <= req_alu_result;
            end else if (load_capture) begin
                result_reg    <= aligned_data;
            end
        end
    end

    // ---------------- next state and outputs ----------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        load_capture = 1'b0;
        dmem_rd_en   = 1'b0;
        dmem_addr    = '0;
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        wb_done      = 1'b0;
        wb_err       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (handshake) begin
                    if (!req_is_load)
                        state_next = ST_WRITE;
                    else if (load_is_bad(req_funct3, req_addr[1:0]))
                        state_next = ST_ERR;
                    else
                        state_next = ST_LOAD_REQ;
                end
            end

            ST_LOAD_REQ: begin
                dmem_rd_en = 1'b1;
                dmem_addr  = {addr_reg[XLEN-1:2], 2'b00};
                cnt_next   = '0;
                state_next = ST_LOAD_WAIT;
            end

            ST_LOAD_WAIT: begin
                dmem_addr = {addr_reg[XLEN-1:2], 2'b00};
                cnt_next  = cnt_reg + 1'b1;
                // Response wins even on the cycle the budget runs out.
                if (dmem_rvalid) begin
                    load_capture = 1'b1;
                    state_next   = ST_WRITE;
                end else if (cnt_next == TIMEOUT_CNT) begin
                    state_next   = ST_ERR;
                end
            end

            ST_WRITE: begin
                rf_we      = write_en;
                rf_waddr   = write_en ? rd_reg : '0;
                rf_wdata   = write_en ? result_reg : '0;
                wb_done    = 1'b1;
                state_next = ST_IDLE;
            end

            ST_ERR: begin
                wb_done    = 1'b1;
                wb_err     = 1'b1;
                state_next = ST_IDLE;
            end

            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_unit.sv
module tb_wb_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_reg_write;
    logic        req_is_load;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic [31:0] req_addr;
    logic [31:0] req_alu_result;
    logic        dmem_rd_en;
    logic [31:0] dmem_addr;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_done;
    logic        wb_err;

    int errors = 0;
    int checks = 0;
    logic seen;

    wb_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_reg_write  (req_reg_write),
        .req_is_load    (req_is_load),
        .req_funct3     (req_funct3),
        .req_rd         (req_rd),
        .req_addr       (req_addr),
        .req_alu_result (req_alu_result),
        .dmem_rd_en     (dmem_rd_en),
        .dmem_addr      (dmem_addr),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .wb_done        (wb_done),
        .wb_err         (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one accept edge, then withdraw it.
    task automatic issue(input logic wr, input logic ld, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] alu);
        req_valid      = 1'b1;
        req_reg_write  = wr;
        req_is_load    = ld;
        req_funct3     = f3;
        req_rd         = rd;
        req_addr       = addr;
        req_alu_result = alu;
        tick();
        req_valid = 1'b0;
    endtask

    // Legal load with response on the first possible cycle; checks the strobe,
    // address and written value.
    task automatic load_ok(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input logic [31:0] exp_data);
        issue(1'b1, 1'b1, f3, 5'd9, addr, 32'h0);
        chk({tag, "_rd_en"}, {31'b0, dmem_rd_en}, 32'd1);
        chk({tag, "_dmem_addr"}, dmem_addr, {addr[31:2], 2'b00});
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = word;
        tick();
        dmem_rvalid = 1'b0;
        chk({tag, "_we"}, {31'b0, rf_we}, 32'd1);
        chk({tag, "_wdata"}, rf_wdata, exp_data);
        $display("load %s addr=%h word=%h -> wdata=%h", tag, addr, word, rf_wdata);
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_reg_write = 1'b0; req_is_load = 1'b0;
        req_funct3 = 3'b000; req_rd = 5'd0; req_addr = 32'h0; req_alu_result = 32'h0;
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;

        // Reset state
        tick(); tick();
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_we", {31'b0, rf_we}, 32'd0);
        chk("rst_done", {31'b0, wb_done}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_ready_before_edge", {31'b0, req_ready}, 32'd0);
        tick();
        chk("rel_ready_after_edge", {31'b0, req_ready}, 32'd1);

        // 1. ALU write to x5
        issue(1'b1, 1'b0, 3'b000, 5'd5, 32'h0, 32'hDEADBEEF);
        chk("alu_we", {31'b0, rf_we}, 32'd1);
        chk("alu_waddr", {27'b0, rf_waddr}, 32'd5);
        chk("alu_wdata", rf_wdata, 32'hDEADBEEF);
        chk("alu_done", {31'b0, wb_done}, 32'd1);
        chk("alu_err", {31'b0, wb_err}, 32'd0);
        chk("alu_ready_busy", {31'b0, req_ready}, 32'd0);
        $display("alu rd=5 -> we=%0d waddr=%0d wdata=%h", rf_we, rf_waddr, rf_wdata);
        tick();
        chk("alu_idle_we", {31'b0, rf_we}, 32'd0);
        chk("alu_idle_done", {31'b0, wb_done}, 32'd0);
        chk("alu_ready_again", {31'b0, req_ready}, 32'd1);

        // 2. Write to x0 suppressed
        issue(1'b1, 1'b0, 3'b000, 5'd0, 32'h0, 32'h00001234);
        chk("x0_we", {31'b0, rf_we}, 32'd0);
        chk("x0_wdata", rf_wdata, 32'h0);
        chk("x0_done", {31'b0, wb_done}, 32'd1);
        chk("x0_err", {31'b0, wb_err}, 32'd0);
        $display("alu rd=0 -> we=%0d done=%0d", rf_we, wb_done);
        tick();

        // 3. Loads with extraction/extension
        load_ok("lb_103",  3'b000, 32'h00000103, 32'h80FF7F01, 32'hFFFFFF80);
        load_ok("lbu_103", 3'b100, 32'h00000103, 32'h80FF7F01, 32'h00000080);
        load_ok("lh_102",  3'b001, 32'h00000102, 32'h80FF7F01, 32'hFFFF80FF);
        load_ok("lhu_100", 3'b101, 32'h00000100, 32'h80FF7F01, 32'h00007F01);
        load_ok("lb_101",  3'b000, 32'h00000101, 32'h80FF7F01, 32'h0000007F);
        load_ok("lhu_102", 3'b101, 32'h00000102, 32'h80FF7F01, 32'h000080FF);

        // 4. Misaligned LW and illegal funct3
        issue(1'b1, 1'b1, 3'b010, 5'd6, 32'h00000102, 32'h0);
        chk("lw_mis_rd_en", {31'b0, dmem_rd_en}, 32'd0);
        chk("lw_mis_done", {31'b0, wb_done}, 32'd1);
        chk("lw_mis_err", {31'b0, wb_err}, 32'd1);
        chk("lw_mis_we", {31'b0, rf_we}, 32'd0);
        $display("lw addr=102 -> done=%0d err=%0d", wb_done, wb_err);
        tick();
        chk("lw_mis_err_clear", {31'b0, wb_err}, 32'd0);
        issue(1'b1, 1'b1, 3'b011, 5'd6, 32'h00000100, 32'h0);
        chk("f3_011_rd_en", {31'b0, dmem_rd_en}, 32'd0);
        chk("f3_011_done", {31'b0, wb_done}, 32'd1);
        chk("f3_011_err", {31'b0, wb_err}, 32'd1);
        chk("f3_011_we", {31'b0, rf_we}, 32'd0);
        $display("funct3=011 -> done=%0d err=%0d", wb_done, wb_err);
        tick();

        // 5a. Timeout: 15 LOAD_WAIT cycles without rvalid
        issue(1'b1, 1'b1, 3'b010, 5'd7, 32'h00000200, 32'h0);
        tick();
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            seen = seen | wb_done;
        end
        chk("to_no_early_done", {31'b0, seen}, 32'd0);
        chk("to_addr_held", dmem_addr, 32'h00000200);
        tick();
        chk("to_done", {31'b0, wb_done}, 32'd1);
        chk("to_err", {31'b0, wb_err}, 32'd1);
        chk("to_we", {31'b0, rf_we}, 32'd0);
        $display("lw timeout -> done=%0d err=%0d", wb_done, wb_err);
        tick();

        // 5b. rvalid on exactly the 15th wait cycle still writes
        issue(1'b1, 1'b1, 3'b010, 5'd8, 32'h00000204, 32'h0);
        tick();
        for (int i = 0; i < 14; i++) tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h11223344;
        tick();
        dmem_rvalid = 1'b0;
        chk("late_we", {31'b0, rf_we}, 32'd1);
        chk("late_waddr", {27'b0, rf_waddr}, 32'd8);
        chk("late_wdata", rf_wdata, 32'h11223344);
        chk("late_err", {31'b0, wb_err}, 32'd0);
        $display("lw rvalid@15 -> we=%0d wdata=%h err=%0d", rf_we, rf_wdata, wb_err);
        tick();

        // 6. Reset during LOAD_WAIT, rvalid after release is ignored
        issue(1'b1, 1'b1, 3'b010, 5'd10, 32'h00000300, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_addr", dmem_addr, 32'h0);
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
        chk("mid_rst_we", {31'b0, rf_we}, 32'd0);
        tick();
        rst = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        #1;
        chk("post_rst_ready_low", {31'b0, req_ready}, 32'd0);
        tick();
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_we", {31'b0, rf_we}, 32'd0);
        tick();
        chk("post_rst_we2", {31'b0, rf_we}, 32'd0);
        chk("post_rst_done", {31'b0, wb_done}, 32'd0);
        dmem_rvalid = 1'b0;
        $display("reset mid-load -> we=%0d ready=%0d", rf_we, req_ready);

        // Recovery: ALU with reg_write=0 retires without write; then normal write
        issue(1'b0, 1'b0, 3'b000, 5'd31, 32'h0, 32'h55AA55AA);
        chk("nowr_we", {31'b0, rf_we}, 32'd0);
        chk("nowr_done", {31'b0, wb_done}, 32'd1);
        tick();
        issue(1'b1, 1'b0, 3'b000, 5'd31, 32'h0, 32'h0BADF00D);
        chk("x31_waddr", {27'b0, rf_waddr}, 32'd31);
        chk("x31_wdata", rf_wdata, 32'h0BADF00D);
        $display("alu rd=31 -> we=%0d wdata=%h", rf_we, rf_wdata);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
